// File: rtl/fpu_decode_pkg.sv
// Shared decode constants, operation enum, FSM encoding and decoded-command struct
// for the RV32F decode/issue stage.
package fpu_decode_pkg;

    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [6:0] F7_FADD   = 7'b0000000;
    localparam logic [6:0] F7_FSUB   = 7'b0000100;
    localparam logic [6:0] F7_FMUL   = 7'b0001000;
    localparam logic [6:0] F7_FDIV   = 7'b0001100;
    localparam logic [6:0] F7_FSQRT  = 7'b0101100;
    localparam logic [6:0] F7_FSGNJ  = 7'b0010000;
    localparam logic [6:0] F7_FMINMX = 7'b0010100;
    localparam logic [6:0] F7_FCMP   = 7'b1010000;
    localparam logic [6:0] F7_FCLASS = 7'b1110000;

    // Word the fetch FSM emits after a restart; completes without touching the datapath.
    localparam logic [31:0] RESTART_WORD = 32'h0000_0010;

    typedef enum logic [4:0] {
        OP_NOP = 5'd0, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT,
        OP_SGNJ, OP_SGNJN, OP_SGNJX, OP_MIN, OP_MAX,
        OP_EQ, OP_LT, OP_LE, OP_CLASS,
        OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD
    } op_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        op_sel_t    op;
        logic       legal;
        logic       nop;
        logic       multi;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [4:0] rd;
        logic [2:0] rm;
    } dec_t;

    function automatic logic is_multi(input op_sel_t op);
        return op inside {OP_DIV, OP_SQRT, OP_MADD, OP_MSUB, OP_NMSUB, OP_NMADD};
    endfunction

endpackage

// File: rtl/fpu_decode_issue_if.sv
// Fetch-side bus of the decode/issue stage: instruction and completion in,
// decoded command and handshake pulses out.
interface fpu_decode_issue_if;
    import fpu_decode_pkg::*;

    logic [31:0] Instruction_in;
    logic        Exec_Done;
    logic        Issue_Valid;
    op_sel_t     Op_Sel;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rs3;
    logic [4:0]  Rd;
    logic [2:0]  Rm;
    logic        Illegal_Instr;
    logic        Multi_Cycle;
    logic        Activation_Signal;
    logic        Timeout_Err;

    modport master (
        output Instruction_in, Exec_Done,
        input  Issue_Valid, Op_Sel, Rs1, Rs2, Rs3, Rd, Rm,
        input  Illegal_Instr, Multi_Cycle, Activation_Signal, Timeout_Err
    );

    modport slave (
        input  Instruction_in, Exec_Done,
        output Issue_Valid, Op_Sel, Rs1, Rs2, Rs3, Rd, Rm,
        output Illegal_Instr, Multi_Cycle, Activation_Signal, Timeout_Err
    );

endinterface

// File: rtl/fpu_op_decoder.sv
// Combinational RV32F OP-FP / fused-op decoder: instruction word -> operation, legality,
// multi-cycle flag and register fields. Zero latency.
module fpu_op_decoder
    import fpu_decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] rm;
    logic       rm_ok;

    assign opcode = instr[6:0];
    assign funct7 = instr[31:25];
    assign rm     = instr[14:12];
    assign rm_ok  = (rm != 3'b101) && (rm != 3'b110);

    always_comb begin
        dec     = '0;
        dec.op  = OP_NOP;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.rm  = rm;
        if (instr == RESTART_WORD) begin
            dec.nop = 1'b1;
        end else if (opcode == OPC_OP_FP) begin
            case (funct7)
                F7_FADD:  begin dec.op = OP_ADD;  dec.legal = rm_ok; end
                F7_FSUB:  begin dec.op = OP_SUB;  dec.legal = rm_ok; end
                F7_FMUL:  begin dec.op = OP_MUL;  dec.legal = rm_ok; end
                F7_FDIV:  begin dec.op = OP_DIV;  dec.legal = rm_ok; end
                F7_FSQRT: begin dec.op = OP_SQRT; dec.legal = rm_ok && (instr[24:20] == 5'd0); end
                // For the non-rounding groups rm selects the sub-operation.
                F7_FSGNJ: begin
                    case (rm)
                        3'b000:  begin dec.op = OP_SGNJ;  dec.legal = 1'b1; end
                        3'b001:  begin dec.op = OP_SGNJN; dec.legal = 1'b1; end
                        3'b010:  begin dec.op = OP_SGNJX; dec.legal = 1'b1; end
                        default: ;
                    endcase
                end
                F7_FMINMX: begin
                    case (rm)
                        3'b000:  begin dec.op = OP_MIN; dec.legal = 1'b1; end
                        3'b001:  begin dec.op = OP_MAX; dec.legal = 1'b1; end
                        default: ;
                    endcase
                end
                F7_FCMP: begin
                    case (rm)
                        3'b000:  begin dec.op = OP_LE; dec.legal = 1'b1; end
                        3'b001:  begin dec.op = OP_LT; dec.legal = 1'b1; end
                        3'b010:  begin dec.op = OP_EQ; dec.legal = 1'b1; end
                        default: ;
                    endcase
                end
                F7_FCLASS: begin
                    if (rm == 3'b001) begin
                        dec.op    = OP_CLASS;
                        dec.legal = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (opcode inside {OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD}) begin
            dec.rs3   = instr[31:27];
            dec.legal = rm_ok && (instr[26:25] == 2'b00);
            case (opcode)
                OPC_FMADD:  dec.op = OP_MADD;
                OPC_FMSUB:  dec.op = OP_MSUB;
                OPC_FNMSUB: dec.op = OP_NMSUB;
                default:    dec.op = OP_NMADD;
            endcase
        end
        dec.multi = dec.legal && is_multi(dec.op);
    end

endmodule

// File: rtl/fpu_decode_issue.sv
// Decode/issue stage: captures a fetched word in IDLE, pulses Issue_Valid/Illegal_Instr next
// cycle, waits (bounded) on Exec_Done for multi-cycle ops, then pulses Activation_Signal.
module fpu_decode_issue
    import fpu_decode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    fpu_decode_issue_if.slave bus
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    dec_t          dec;
    dec_t          cmd_q;
    logic [CW-1:0] cnt;
    logic          timeout_q;
    logic          timeout_set;
    logic          capture;

    fpu_op_decoder u_dec (
        .instr (bus.Instruction_in),
        .dec   (dec)
    );

    assign capture = (state == ST_IDLE) && (bus.Instruction_in != 32'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt             = state;
        timeout_set           = 1'b0;
        bus.Issue_Valid       = 1'b0;
        bus.Illegal_Instr     = 1'b0;
        bus.Multi_Cycle       = 1'b0;
        bus.Activation_Signal = 1'b0;
        case (state)
            ST_IDLE: begin
                if (capture) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.Issue_Valid   = cmd_q.legal;
                bus.Illegal_Instr = !cmd_q.legal && !cmd_q.nop;
                // A datapath that finishes in the issue cycle skips WAIT entirely.
                state_nxt = (cmd_q.multi && !bus.Exec_Done) ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                bus.Multi_Cycle = 1'b1;
                if (bus.Exec_Done) begin
                    state_nxt = ST_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_set = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            default: begin
                bus.Activation_Signal = 1'b1;
                state_nxt             = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          cmd_q <= '0;
        else if (capture) cmd_q <= dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (state == ST_WAIT) cnt <= cnt + CW'(1);
        else if (state == ST_DONE) cnt <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              timeout_q <= 1'b0;
        else if (timeout_set) timeout_q <= 1'b1;
    end

    assign bus.Op_Sel      = cmd_q.op;
    assign bus.Rs1         = cmd_q.rs1;
    assign bus.Rs2         = cmd_q.rs2;
    assign bus.Rs3         = cmd_q.rs3;
    assign bus.Rd          = cmd_q.rd;
    assign bus.Rm          = cmd_q.rm;
    assign bus.Timeout_Err = timeout_q;

endmodule

// File: tb/tb_fpu_decode_issue.sv
// Directed plus randomized bench for fpu_decode_issue against a table-driven reference
// decoder and a per-instruction cycle trace model.
module tb_fpu_decode_issue;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   tout_ref = 1'b0;

    fpu_decode_issue_if bus();

    fpu_decode_issue #(.TIMEOUT_CYCLES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Legal OP-FP encodings: funct7 plus the set of rm values accepted (bit i = rm i).
    typedef struct {
        logic [6:0] f7;
        logic [7:0] rm_ok;
        int         op;
        bit         multi;
        bit         rs2z;
    } fp_ent_t;

    localparam logic [7:0] RND = 8'b1001_1111;
    fp_ent_t    tbl[$];
    logic [6:0] fused_opc[4];

    function automatic void add_ent(input logic [6:0] f7, input logic [7:0] m, input int op,
                                    input bit multi, input bit rs2z);
        fp_ent_t e;
        e.f7 = f7; e.rm_ok = m; e.op = op; e.multi = multi; e.rs2z = rs2z;
        tbl.push_back(e);
    endfunction

    // kind: 0 restart/nop, 1 illegal, 2 single-cycle, 3 multi-cycle
    function automatic void ref_dec(input logic [31:0] w, output int kind, output int op);
        logic [2:0] rm;
        rm   = w[14:12];
        kind = 1;
        op   = 0;
        if (w == 32'h0000_0010) begin
            kind = 0;
        end else if (w[6:0] == 7'b1010011) begin
            foreach (tbl[i]) begin
                if (tbl[i].f7 == w[31:25] && tbl[i].rm_ok[rm] && (!tbl[i].rs2z || w[24:20] == 5'd0)) begin
                    kind = tbl[i].multi ? 3 : 2;
                    op   = tbl[i].op;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w[6:0] == fused_opc[i] && w[26:25] == 2'b00 && RND[rm]) begin
                    kind = 3;
                    op   = 15 + i;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ":iv"},   bus.Issue_Valid, 0);
        chk({tag, ":ill"},  bus.Illegal_Instr, 0);
        chk({tag, ":mc"},   bus.Multi_Cycle, 0);
        chk({tag, ":act"},  bus.Activation_Signal, 0);
        chk({tag, ":tout"}, bus.Timeout_Err, 0);
        chk({tag, ":op"},   bus.Op_Sel, 0);
        chk({tag, ":regs"}, {bus.Rs1, bus.Rs2, bus.Rs3, bus.Rd, bus.Rm}, 0);
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] w, input int op);
        chk({tag, ":op"},  bus.Op_Sel, op);
        chk({tag, ":rd"},  bus.Rd,  w[11:7]);
        chk({tag, ":rs1"}, bus.Rs1, w[19:15]);
        chk({tag, ":rs2"}, bus.Rs2, w[24:20]);
        chk({tag, ":rs3"}, bus.Rs3, (op >= 15) ? w[31:27] : 5'd0);
        chk({tag, ":rm"},  bus.Rm,  w[14:12]);
    endtask

    // dly: WAIT cycle in which Exec_Done pulses; 0 = already high in ISSUE; <0 = never
    task automatic run(input logic [31:0] w, input int dly, input string tag);
        int kind, op, nwait;
        ref_dec(w, kind, op);
        bus.Instruction_in = w;
        bus.Exec_Done      = 1'b0;
        cyc();
        bus.Instruction_in = $urandom | 32'h1;
        chk({tag, ":issue_iv"},  bus.Issue_Valid, kind >= 2);
        chk({tag, ":issue_ill"}, bus.Illegal_Instr, kind == 1);
        chk({tag, ":issue_mc"},  bus.Multi_Cycle, 0);
        chk({tag, ":issue_act"}, bus.Activation_Signal, 0);
        if (kind >= 2) chk_fields({tag, ":issue"}, w, op);
        nwait = 0;
        if (kind == 3) begin
            if (dly == 0) bus.Exec_Done = 1'b1;
            else nwait = (dly < 0 || dly > 64) ? 64 : dly;
        end
        cyc();
        for (int k = 1; k <= nwait; k++) begin
            chk({tag, ":wait_mc"},  bus.Multi_Cycle, 1);
            chk({tag, ":wait_act"}, bus.Activation_Signal, 0);
            bus.Exec_Done = (k == dly);
            cyc();
        end
        if (kind == 3 && dly != 0 && (dly < 0 || dly > 64)) tout_ref = 1'b1;
        bus.Exec_Done      = 1'b0;
        bus.Instruction_in = 32'h0;
        chk({tag, ":done_act"},  bus.Activation_Signal, 1);
        chk({tag, ":done_mc"},   bus.Multi_Cycle, 0);
        chk({tag, ":done_iv"},   bus.Issue_Valid | bus.Illegal_Instr, 0);
        chk({tag, ":done_tout"}, bus.Timeout_Err, tout_ref);
        if (kind >= 2) chk_fields({tag, ":hold"}, w, op);
        cyc();
        chk({tag, ":idle_act"}, bus.Activation_Signal, 0);
    endtask

    function automatic logic [31:0] gen_word();
        int          r;
        fp_ent_t     e;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        if (r <= 5) begin
            e = tbl[$urandom_range(0, tbl.size() - 1)];
            w = {e.f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'b1010011};
            if (e.rs2z && $urandom_range(0, 3) != 0) w[24:20] = 5'd0;
        end else if (r <= 7) begin
            w = {5'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
                 fused_opc[$urandom_range(0, 3)]};
        end else if (r == 8) begin
            w = $urandom | 32'h1;
        end else begin
            w = 32'h0000_0010;
        end
        return w;
    endfunction

    initial begin
        add_ent(7'b0000000, RND, 1, 0, 0);
        add_ent(7'b0000100, RND, 2, 0, 0);
        add_ent(7'b0001000, RND, 3, 0, 0);
        add_ent(7'b0001100, RND, 4, 1, 0);
        add_ent(7'b0101100, RND, 5, 1, 1);
        add_ent(7'b0010000, 8'b001, 6, 0, 0);
        add_ent(7'b0010000, 8'b010, 7, 0, 0);
        add_ent(7'b0010000, 8'b100, 8, 0, 0);
        add_ent(7'b0010100, 8'b001, 9, 0, 0);
        add_ent(7'b0010100, 8'b010, 10, 0, 0);
        add_ent(7'b1010000, 8'b100, 11, 0, 0);
        add_ent(7'b1010000, 8'b010, 12, 0, 0);
        add_ent(7'b1010000, 8'b001, 13, 0, 0);
        add_ent(7'b1110000, 8'b010, 14, 0, 0);
        fused_opc[0] = 7'b1000011;
        fused_opc[1] = 7'b1000111;
        fused_opc[2] = 7'b1001011;
        fused_opc[3] = 7'b1001111;

        rst = 1'b1;
        bus.Instruction_in = 32'h0;
        bus.Exec_Done      = 1'b0;
        cyc();
        cyc();
        chk_zero("reset");
        rst = 1'b0;
        cyc();

        run(32'h0020_81D3, 0, "fadd");
        run(32'h1820_81D3, 5, "fdiv5");
        run(32'h1820_81D3, 0, "fdiv_early");
        run(32'hFFFF_FFFF, 0, "illegal_ff");
        run(32'h0020_D1D3, 0, "fadd_rm101");
        run(32'h0020_E1D3, 0, "fadd_rm110");
        run(32'h0000_0010, 0, "restart");
        run(32'h5800_8053, 64, "fsqrt_done_at_limit");

        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("zero_idle_act", bus.Activation_Signal, 0);
            chk("zero_idle_iv",  bus.Issue_Valid | bus.Illegal_Instr | bus.Multi_Cycle, 0);
        end

        bus.Instruction_in = 32'h1820_81D3;
        cyc();
        bus.Instruction_in = 32'h0;
        cyc();
        cyc();
        cyc();
        chk("midwait_mc", bus.Multi_Cycle, 1);
        #2 rst = 1'b1;
        #1;
        chk_zero("midwait_rst");
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("post_rst_act", bus.Activation_Signal, 0);
        end

        for (int i = 0; i < 250; i++) begin
            run(gen_word(), $urandom_range(0, 8), "rand");
        end

        run(32'h5800_8053, -1, "fsqrt_timeout");
        for (int i = 0; i < 30; i++) begin
            run(gen_word(), $urandom_range(0, 6), "rand_sticky");
        end

        rst = 1'b1;
        #1;
        tout_ref = 1'b0;
        chk_zero("tout_clear");
        cyc();
        rst = 1'b0;
        cyc();
        run(32'h0020_81D3, 0, "fadd_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
